// File: rtl/trace_pkg.sv
// Shared types and constants for the commit-info trace producer.
package trace_pkg;

  localparam int unsigned XLEN = 32;

  // One retired instruction as seen by the commit sink (96 bits).
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nextpc;
    logic [XLEN-1:0] inst;
  } commit_rec_t;

  localparam logic [XLEN-1:0] TRACE_RESET_PC        = 32'h8000_0000;
  localparam int unsigned     TRACE_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head is read straight from storage.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         elem_t = commit_rec_t
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  elem_t push_data,
  input  logic  pop,
  output elem_t head,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  elem_t         mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; pointers wrap naturally through the extra MSB.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/commit_trace_src.sv
// Commit-trace producer: buffers retire events, streams them to the sink,
// and flags hangs and pc discontinuities in the retire stream.
module commit_trace_src
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = TRACE_TIMEOUT_DEFAULT,
  parameter logic [31:0] RESET_PC = TRACE_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_nextpc,
  input  logic [31:0] wb_inst,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_nextpc,
  output logic [31:0] trace_inst,
  output logic [63:0] retire_cnt,
  output logic        hang,
  output logic        pc_err,
  output logic [31:0] pc_err_pc
);

  localparam int unsigned IDLE_W = 32;

  commit_rec_t       wb_rec;
  commit_rec_t       head_rec;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [31:0]       exp_pc;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_nxt;

  assign wb_rec = '{pc: wb_pc, nextpc: wb_nextpc, inst: wb_inst};

  // Ready depends only on registered occupancy; valid is masked during reset
  // so a sink cannot consume a record that the reset is about to discard.
  assign wb_ready    = !fifo_full;
  assign trace_valid = !fifo_empty && !reset;
  assign push        = wb_valid && wb_ready;
  assign pop         = trace_valid && trace_ready;

  assign trace_pc     = head_rec.pc;
  assign trace_nextpc = head_rec.nextpc;
  assign trace_inst   = head_rec.inst;

  trace_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (commit_rec_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (wb_rec),
    .pop       (pop),
    .head      (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next idle count: cleared by a retire, otherwise saturating increment.
  always_comb begin
    idle_nxt = idle_cnt;
    if (push)                 idle_nxt = '0;
    else if (idle_cnt != '1)  idle_nxt = idle_cnt + IDLE_W'(1);
  end

  // Retire counter and hang watchdog; hang rises on the edge the count reaches TIMEOUT.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt <= '0;
      idle_cnt   <= '0;
      hang       <= 1'b0;
    end else begin
      if (push) retire_cnt <= retire_cnt + 64'(1);
      idle_cnt <= idle_nxt;
      if (idle_nxt >= IDLE_W'(TIMEOUT)) hang <= 1'b1;
    end
  end

  // Pc-continuity checker; only the first break is captured.
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_pc    <= RESET_PC;
      pc_err    <= 1'b0;
      pc_err_pc <= '0;
    end else if (push) begin
      exp_pc <= wb_nextpc;
      if ((wb_pc != exp_pc) && !pc_err) begin
        pc_err    <= 1'b1;
        pc_err_pc <= wb_pc;
      end
    end
  end

endmodule
